bn_param_mem_writer: RTL and testbench
======================================

# bn_param_mem_writer

Streams per-channel batch-normalisation parameters from a simple valid/ready input into the BN parameter memory write port (`bn_mem_wen_a` / `bn_mem_addr_a` / `bn_mem_din_a`) of the generic convolution datapath. It sits between the parameter DMA and the BN/activation unit's parameter RAM. It generalises the fixed 16-bit-address / 64-bit-entry write port to parametrised widths and depth. It also synthesises the A=1 / B=0 parameters on chip, so those fields are never transferred.

## Interface
Parameters:
- `PARAM_W`, 32: width of one BN parameter (A or B); memory entry width is 2*`PARAM_W`.
- `IN_W`, 32: input stream width; legal values are `PARAM_W` (one field per beat) or 2*`PARAM_W` (one {B,A} pair per beat).
- `ADDR_W`, 16: memory address width; the maximum number of channels is 2^`ADDR_W`.

Ports:
- `clk`  in  1  clock; every register is clocked on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse that starts a load; ignored unless `busy`=0.
- `chn_n`  in  `ADDR_W`  channel count − 1; sampled on `start`.
- `is_a_eq_1`  in  1  A field is not transmitted; A = 1 << `quat_accrc`; sampled on `start`.
- `is_b_eq_0`  in  1  B field is not transmitted; B = 0; sampled on `start`.
- `quat_accrc`  in  5  fixed-point quantisation precision; sampled on `start`.
- `busy`  out  1  high from the cycle after `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse when the load completes.
- `s_data`  in  `IN_W`  parameter data; A occupies the low field, B the high field.
- `s_valid`  in  1  source valid.
- `s_ready`  out  1  sink ready.
- `s_last`  in  1  marks the final beat of the load.
- `bn_mem_wen_a`  out  1  memory write enable.
- `bn_mem_addr_a`  out  `ADDR_W`  memory write address (the channel index).
- `bn_mem_din_a`  out  2*`PARAM_W`  memory write data, {B, A}.
- `err_last`  out  1  sticky `s_last` protocol error.

## Operation
- FSM states: IDLE, GET_A, GET_B, GEN, DONE.
- IDLE + `start`: latch the configuration and clear the channel counter `ch`. The next state depends on the flags:
  - neither flag set → GET_A;
  - only `is_a_eq_1` set → GET_B;
  - both flags set → GEN.
  - Special case: with `is_a_eq_1`=0, `IN_W`=2*`PARAM_W` always goes to GET_A, which consumes the full pair in one beat.
- GET_A handshake (`s_valid`&`s_ready`):
  - Capture A, or with `IN_W`=2*`PARAM_W` capture both fields.
  - If B is still needed from the stream (`IN_W`=`PARAM_W` and `is_b_eq_0`=0) → GET_B.
  - Otherwise commit the entry.
- GET_B handshake: capture B and commit the entry.
- GEN: commit one synthesised entry every cycle; no handshakes occur.
- Commit:
  - Flag overrides apply to the entry, even when the stream carried the flagged field.
  - On the next cycle `bn_mem_wen_a`=1, `bn_mem_addr_a`=`ch`, `bn_mem_din_a`={B,A}.
  - If `ch`==`chn_n` → DONE; else `ch`+1 and return to the channel's first state.
- DONE: `done`=1 for one cycle → IDLE.
- `s_ready`=1 only in GET_A/GET_B; it does not depend on `s_valid`.
- Beats arriving while `s_ready`=0 are not consumed.
- `start` while `busy` is ignored; the configuration is unchanged.
- `chn_n`=0 loads exactly one entry. `chn_n`=2^`ADDR_W`−1 fills the memory and never wraps the address.
- Reset mid-load aborts immediately. No further writes occur; partial memory contents are left as written.

## Timing
- All outputs reset to 0, and `s_ready` reset to 0.
- Latency: the final-field handshake at edge t gives `bn_mem_wen_a` high in the cycle after t, for exactly one cycle.
- Throughput:
  - 1 entry per beat with `IN_W`=2*`PARAM_W` or with one flag set;
  - 1 entry per 2 beats with `IN_W`=`PARAM_W` and no flags;
  - 1 entry per cycle in GEN.
- `done` and `busy` timing:
  - `done` is high in the same cycle as the final `bn_mem_wen_a`.
  - `busy` falls the cycle after `done`.
  - The earliest next `start` is accepted in the cycle `busy`=0.
- A=1 value: the low `PARAM_W` bits of (1 << `quat_accrc`). It is 0 if `quat_accrc` ≥ `PARAM_W`.

## Configuration
- Macro `BN_PARAM_WR_LAST_CHK_EN` defined:
  - `err_last` sets when `s_last`=1 on a non-final accepted beat, or `s_last`=0 on the final accepted beat.
  - `err_last` is cleared on an accepted `start`.
  - It never alters the FSM or the writes.
  - In GEN no beats occur, so `err_last` stays 0.
- Macro not defined: `err_last` is tied to 0 and `s_last` is ignored.

## Test plan
- `IN_W`=32, `chn_n`=2, no flags, beats A0,B0,A1,B1,A2,B2 → writes at addr 0/1/2 of {B,A}; `done` coincides with the addr-2 write.
- `IN_W`=64, `chn_n`=3, `is_a_eq_1`=1, `quat_accrc`=12, beats carrying A=0xDEAD → all writes have A=0x1000, B taken from the stream; 4 beats consumed.
- Both flags set, `chn_n`=7 → 8 consecutive-cycle writes of {0, 1<<`quat_accrc`}; `s_ready` stays 0.
- Random `s_valid` gaps, plus a `start` pulsed mid-load → identical memory image; the second `start` is ignored.
- With `BN_PARAM_WR_LAST_CHK_EN`, `s_last` asserted on beat 2 of 6 → `err_last`=1 stays set until the next `start`; the writes are unaffected.
- `rst_n` dropped after the addr-1 write → no further `bn_mem_wen_a`; all outputs read 0 during reset.

Source files
------------

// File: rtl/bn_param_mem_writer.sv
// Streams per-channel {B,A} batch-norm parameters into the BN parameter RAM write port,
// synthesising A=1<<quat_accrc / B=0 on chip. Optional s_last checker: BN_PARAM_WR_LAST_CHK_EN.
module bn_param_mem_writer #(
    parameter int PARAM_W = 32,
    parameter int IN_W    = 32,
    parameter int ADDR_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    chn_n,
    input  logic                 is_a_eq_1,
    input  logic                 is_b_eq_0,
    input  logic [4:0]           quat_accrc,
    output logic                 busy,
    output logic                 done,
    input  logic [IN_W-1:0]      s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    output logic                 bn_mem_wen_a,
    output logic [ADDR_W-1:0]    bn_mem_addr_a,
    output logic [2*PARAM_W-1:0] bn_mem_din_a,
    output logic                 err_last
);
    // Handshake: a beat is consumed on a rising edge where s_valid && s_ready; s_ready is a
    // pure function of state (high only in GET_A/GET_B) and never looks at s_valid.
    localparam bit PAIR = (IN_W == 2*PARAM_W);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GEN, DONE} state_t;
    state_t state, state_nx, first_st;

    logic [ADDR_W-1:0]    ch, chn_n_r;
    logic                 a_one_r, b_zero_r;
    logic [4:0]           quat_r;
    logic [PARAM_W-1:0]   a_r, a_gen, a_src, b_src, a_val, b_val, s_lo, s_hi;
    logic [2*PARAM_W-1:0] s_wide;
    logic                 accept_start, fire, commit, last_ch;

    function automatic state_t entry_state(input logic a_one, input logic b_zero);
        if (!a_one)       return GET_A;
        else if (!b_zero) return GET_B;
        else              return GEN;
    endfunction

    assign accept_start = (state == IDLE) && start;
    assign s_ready      = (state == GET_A) || (state == GET_B);
    assign fire         = s_ready && s_valid;
    assign last_ch      = (ch == chn_n_r);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign first_st     = entry_state(a_one_r, b_zero_r);

    // Narrow streams are zero-extended so both field slices always exist.
    assign s_wide = (2*PARAM_W)'(s_data);
    assign s_lo   = s_wide[PARAM_W-1:0];
    assign s_hi   = s_wide[2*PARAM_W-1:PARAM_W];

    always_comb begin
        a_gen = '0;
        for (int i = 0; i < PARAM_W; i++) a_gen[i] = (i == int'(quat_r));
    end

    // Flag overrides win even when the stream carried the field.
    assign a_src = (state == GET_A) ? s_lo : a_r;
    assign b_src = PAIR ? s_hi : s_lo;
    assign a_val = a_one_r ? a_gen : a_src;
    assign b_val = b_zero_r ? '0 : b_src;

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = entry_state(is_a_eq_1, is_b_eq_0);
            GET_A:   if (fire) begin
                         if (PAIR || b_zero_r) commit = 1'b1;
                         else                  state_nx = GET_B;
                     end
            GET_B:   if (fire) commit = 1'b1;
            GEN:     commit = 1'b1;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (commit) state_nx = last_ch ? DONE : first_st;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch            <= '0;
            chn_n_r       <= '0;
            a_one_r       <= 1'b0;
            b_zero_r      <= 1'b0;
            quat_r        <= '0;
            a_r           <= '0;
            bn_mem_wen_a  <= 1'b0;
            bn_mem_addr_a <= '0;
            bn_mem_din_a  <= '0;
        end else begin
            bn_mem_wen_a <= commit;
            if (accept_start) begin
                ch       <= '0;
                chn_n_r  <= chn_n;
                a_one_r  <= is_a_eq_1;
                b_zero_r <= is_b_eq_0;
                quat_r   <= quat_accrc;
            end
            if ((state == GET_A) && fire) a_r <= s_lo;
            // The counter holds on the last channel so a full-depth load never wraps.
            if (commit) begin
                bn_mem_addr_a <= ch;
                bn_mem_din_a  <= {b_val, a_val};
                if (!last_ch) ch <= ch + 1'b1;
            end
        end
    end

`ifdef BN_PARAM_WR_LAST_CHK_EN
    logic final_beat;
    assign final_beat = commit && last_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_last <= 1'b0;
        else if (accept_start)                  err_last <= 1'b0;
        else if (fire && (s_last != final_beat)) err_last <= 1'b1;
    end
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign err_last      = 1'b0;
`endif

endmodule

// File: tb/tb_bn_param_mem_writer.sv
// Directed bench for bn_param_mem_writer: narrow (IN_W=32) and pair (IN_W=64) instances
// share one driver; writes are captured at the falling edge and scored against a model.
`timescale 1ns/1ps
module tb_bn_param_mem_writer;
    localparam int PW = 32;
    localparam int AW = 16;
    localparam int W  = 1 + AW + 2*PW;   // {done, addr, din}
`ifdef BN_PARAM_WR_LAST_CHK_EN
    localparam bit LAST_CHK = 1'b1;
`else
    localparam bit LAST_CHK = 1'b0;
`endif

    typedef struct {
        bit            w64;
        logic [AW-1:0] chn;
        bit            a1;
        bit            b0;
        logic [4:0]    quat;
        logic [PW-1:0] exp_a;
        int            exp_beats;
        int            exp_cycles;
    } case_t;

    logic          clk, rst_n, start, is_a_eq_1, is_b_eq_0, s_valid, s_last, sel64;
    logic [AW-1:0] chn_n;
    logic [4:0]    quat_accrc;
    logic [63:0]   s_data;

    logic          busy32, done32, ready32, wen32, err32;
    logic [AW-1:0] addr32;
    logic [63:0]   din32;
    logic          busy64, done64, ready64, wen64, err64;
    logic [AW-1:0] addr64;
    logic [63:0]   din64;
    logic          start32, start64, valid32, valid64;

    logic          busy, done, s_ready, wen, err_last;
    logic [AW-1:0] addr;
    logic [63:0]   din;

    assign start32 = start && !sel64;
    assign start64 = start && sel64;
    assign valid32 = s_valid && !sel64;
    assign valid64 = s_valid && sel64;
    assign busy     = sel64 ? busy64  : busy32;
    assign done     = sel64 ? done64  : done32;
    assign s_ready  = sel64 ? ready64 : ready32;
    assign wen      = sel64 ? wen64   : wen32;
    assign addr     = sel64 ? addr64  : addr32;
    assign din      = sel64 ? din64   : din32;
    assign err_last = sel64 ? err64   : err32;

    bn_param_mem_writer #(.PARAM_W(PW), .IN_W(32), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start32), .chn_n(chn_n),
        .is_a_eq_1(is_a_eq_1), .is_b_eq_0(is_b_eq_0), .quat_accrc(quat_accrc),
        .busy(busy32), .done(done32), .s_data(s_data[31:0]), .s_valid(valid32),
        .s_ready(ready32), .s_last(s_last), .bn_mem_wen_a(wen32),
        .bn_mem_addr_a(addr32), .bn_mem_din_a(din32), .err_last(err32)
    );

    bn_param_mem_writer #(.PARAM_W(PW), .IN_W(64), .ADDR_W(AW)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .chn_n(chn_n),
        .is_a_eq_1(is_a_eq_1), .is_b_eq_0(is_b_eq_0), .quat_accrc(quat_accrc),
        .busy(busy64), .done(done64), .s_data(s_data), .s_valid(valid64),
        .s_ready(ready64), .s_last(s_last), .bn_mem_wen_a(wen64),
        .bn_mem_addr_a(addr64), .bn_mem_din_a(din64), .err_last(err64)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int ready_cycles = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        if (wen) got_q.push_back({done, addr, din});
        if (s_ready) ready_cycles++;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] a_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0001_0011;
    endfunction

    function automatic logic [PW-1:0] b_of(input int i);
        return 32'hB000_0000 + 32'(i) * 32'h0100_0007;
    endfunction

    // driver
    task automatic run_load(input case_t c, input bit gaps, input bit mid_start, input int bad_last);
        logic [63:0] beats[$];
        int base, rdy0, bi, cycles, nb, nent;
        bit got_done, fire;
        nent = int'(c.chn) + 1;
        for (int i = 0; i < nent; i++) begin
            if (c.w64) begin
                if (!(c.a1 && c.b0)) beats.push_back({b_of(i), c.a1 ? 32'h0000_DEAD : a_of(i)});
            end else begin
                if (!c.a1) beats.push_back({32'h0, a_of(i)});
                if (!c.b0) beats.push_back({32'h0, b_of(i)});
            end
            exp_q.push_back({(i == nent - 1), AW'(i), c.b0 ? 32'h0 : b_of(i), c.a1 ? c.exp_a : a_of(i)});
        end
        nb = beats.size();

        @(negedge clk);
        rdy0 = ready_cycles;
        base = got_q.size();
        sel64 = c.w64; chn_n = c.chn; is_a_eq_1 = c.a1; is_b_eq_0 = c.b0;
        quat_accrc = c.quat; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chn_n = AW'($urandom); is_a_eq_1 = 1'($urandom_range(0, 1));
        is_b_eq_0 = 1'($urandom_range(0, 1)); quat_accrc = 5'($urandom);
        bi = 0; cycles = 0; got_done = 1'b0;
        while (!got_done && cycles < 500) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (bi < nb && (!gaps || $urandom_range(0, 2) != 0)) begin
                    s_valid = 1'b1;
                    s_data  = beats[bi];
                    s_last  = (bad_last >= 0) ? (bi == bad_last) : (bi == nb - 1);
                end else begin
                    s_valid = 1'b0;
                    s_data  = {$urandom, $urandom};
                    s_last  = 1'b0;
                end
                start = mid_start && (cycles == 2);
                if (start) begin
                    chn_n = 16'd5; is_a_eq_1 = 1'b1; is_b_eq_0 = 1'b1; quat_accrc = 5'd9;
                end
                fire = s_valid && s_ready;
                @(negedge clk);
                if (fire) bi++;
                cycles++;
            end
        end
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        check("done_seen", W'(got_done), W'(1));
        check("busy_at_done", W'(busy), W'(1));
        @(negedge clk);
        check("busy_after_done", W'(busy), W'(0));
        check("done_one_cycle", W'(done), W'(0));
        for (int k = 0; k < nent; k++) begin
            if (base + k < got_q.size()) check($sformatf("write_%0d", k), got_q[base + k], exp_q[0]);
            else check($sformatf("write_%0d_missing", k), W'(0), W'(1));
            void'(exp_q.pop_front());
        end
        check("write_count", W'(got_q.size() - base), W'(nent));
        check("beats_consumed", W'(bi), W'(c.exp_beats));
        if (!gaps) begin
            check("load_cycles", W'(cycles), W'(c.exp_cycles));
            check("ready_cycles", W'(ready_cycles - rdy0), W'(c.exp_beats));
        end
        check("err_last", W'(err_last), (bad_last >= 0) ? W'(LAST_CHK) : W'(0));
        if (bad_last >= 0) begin
            repeat (3) @(negedge clk);
            check("err_last_sticky", W'(err_last), W'(LAST_CHK));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen32"},   W'(wen32),   W'(0));
        check({tag, "_addr32"},  W'(addr32),  W'(0));
        check({tag, "_din32"},   W'(din32),   W'(0));
        check({tag, "_busy32"},  W'(busy32),  W'(0));
        check({tag, "_done32"},  W'(done32),  W'(0));
        check({tag, "_ready32"}, W'(ready32), W'(0));
        check({tag, "_err32"},   W'(err32),   W'(0));
        check({tag, "_wen64"},   W'(wen64),   W'(0));
        check({tag, "_ready64"}, W'(ready64), W'(0));
    endtask

    case_t cases[11];

    initial begin
        int base, bi, k;
        bit fire;
        cases[0]  = '{1'b0, 16'd2, 1'b0, 1'b0, 5'd0,  32'h0,         6, 6};
        cases[1]  = '{1'b0, 16'd0, 1'b0, 1'b0, 5'd0,  32'h0,         2, 2};
        cases[2]  = '{1'b0, 16'd3, 1'b1, 1'b0, 5'd12, 32'h0000_1000, 4, 4};
        cases[3]  = '{1'b0, 16'd2, 1'b0, 1'b1, 5'd0,  32'h0,         3, 3};
        cases[4]  = '{1'b0, 16'd7, 1'b1, 1'b1, 5'd5,  32'h0000_0020, 0, 8};
        cases[5]  = '{1'b0, 16'd1, 1'b1, 1'b0, 5'd31, 32'h8000_0000, 2, 2};
        cases[6]  = '{1'b0, 16'd0, 1'b1, 1'b1, 5'd0,  32'h0000_0001, 0, 1};
        cases[7]  = '{1'b1, 16'd3, 1'b1, 1'b0, 5'd12, 32'h0000_1000, 4, 4};
        cases[8]  = '{1'b1, 16'd1, 1'b0, 1'b0, 5'd0,  32'h0,         2, 2};
        cases[9]  = '{1'b1, 16'd2, 1'b0, 1'b1, 5'd0,  32'h0,         3, 3};
        cases[10] = '{1'b1, 16'd1, 1'b1, 1'b1, 5'd3,  32'h0000_0008, 0, 2};

        rst_n = 1'b0; start = 1'b0; chn_n = '0; is_a_eq_1 = 1'b0; is_b_eq_0 = 1'b0;
        quat_accrc = '0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; sel64 = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_load(cases[i], 1'b0, 1'b0, -1);

        // valid gaps plus an ignored start mid-load
        run_load(cases[0], 1'b1, 1'b1, -1);
        // s_last on beat 2 of 6, then a clean load clears it
        run_load(cases[0], 1'b0, 1'b0, 1);
        run_load(cases[1], 1'b0, 1'b0, -1);

        // reset after the addr-1 write aborts the load
        @(negedge clk);
        sel64 = 1'b0; chn_n = 16'd3; is_a_eq_1 = 1'b0; is_b_eq_0 = 1'b0; start = 1'b1;
        base = got_q.size();
        @(negedge clk);
        start = 1'b0; bi = 0; k = 0;
        while (got_q.size() - base < 2 && k < 50) begin
            s_valid = 1'b1;
            s_data  = {32'h0, bi[0] ? b_of(bi / 2) : a_of(bi / 2)};
            fire = s_ready;
            @(negedge clk);
            if (fire) bi++;
            k++;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        s_valid = 1'b0;
        check("abort_write_count", W'(got_q.size() - base), W'(2));
        if (got_q.size() - base >= 2) begin
            check("abort_write_0", got_q[base],     {1'b0, 16'd0, b_of(0), a_of(0)});
            check("abort_write_1", got_q[base + 1], {1'b0, 16'd1, b_of(1), a_of(1)});
        end
        check("abort_busy", W'(busy), W'(0));

        run_load(cases[2], 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
